// File: rtl/piezo_rx_qualifier.sv
// Piezo receive qualifier: synchronizes the raw comparator output, accepts an
// echo only after MIN_HIGH consecutive high samples, enforces a dead time after
// each echo and blanks reception around the local transmitter. A one-cycle
// strobe is emitted per accepted echo, with saturating accept/reject counters.
module piezo_rx_qualifier #(
    parameter int SYNC_STAGES    = 2,
    parameter int MIN_HIGH       = 8,
    parameter int HOLDOFF_CYCLES = 1000,
    parameter int BLANK_CYCLES   = 50000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        piezo_raw_in,
    input  logic        tx_active,
    input  logic        clear_counts,
    output logic        pulse_out,
    output logic [15:0] pulse_count,
    output logic [15:0] glitch_count,
    output logic [2:0]  state_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_QUALIFY = 3'd2;
    localparam logic [2:0] S_HOLDOFF = 3'd3;
    localparam logic [2:0] S_BLANK   = 3'd4;

    // Terminal values of the shared counter in each state that uses it
    localparam logic [31:0] QUAL_LAST = 32'(MIN_HIGH - 1);
    localparam logic [31:0] HOLD_END  = 32'(HOLDOFF_CYCLES);
    localparam logic [31:0] BLANK_END = 32'(BLANK_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [2:0]             state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   pulse_q;
    logic                   pulse_inc, glitch_inc;
    logic [15:0]            pulse_cnt_q, glitch_cnt_q;

    // Metastability chain; only its last flop is used by the FSM
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], piezo_raw_in};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Next-state logic: disable beats transmit blanking, which beats the qualifier
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_inc  = 1'b0;
        glitch_inc = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (tx_active) begin
            // Own transmit: drop any partial qualification without counting it
            state_d = S_BLANK;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
                end
                S_ARMED: begin
                    if (sync) begin
                        state_d = S_QUALIFY;
                        cnt_d   = 32'd1;
                    end
                end
                S_QUALIFY: begin
                    if (!sync) begin
                        glitch_inc = 1'b1;
                        state_d    = S_ARMED;
                        cnt_d      = '0;
                    end else if (cnt_q >= QUAL_LAST) begin
                        pulse_inc = 1'b1;
                        state_d   = S_HOLDOFF;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_HOLDOFF: begin
                    // Needs a low sample after the dead time, so a stuck-high input never re-fires
                    if (cnt_q >= HOLD_END) begin
                        if (!sync) begin
                            state_d = S_ARMED;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_BLANK: begin
                    if (cnt_q >= BLANK_END) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, shared counter and registered echo strobe
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_inc;
        end
    end

    // Saturating statistics; clear takes priority over a same-cycle increment
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_cnt_q  <= '0;
            glitch_cnt_q <= '0;
        end else if (clear_counts) begin
            pulse_cnt_q  <= '0;
            glitch_cnt_q <= '0;
        end else begin
            if (pulse_inc && (pulse_cnt_q != 16'hFFFF))
                pulse_cnt_q <= pulse_cnt_q + 16'd1;
            if (glitch_inc && (glitch_cnt_q != 16'hFFFF))
                glitch_cnt_q <= glitch_cnt_q + 16'd1;
        end
    end

    assign pulse_out    = pulse_q;
    assign pulse_count  = pulse_cnt_q;
    assign glitch_count = glitch_cnt_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_piezo_rx_qualifier.sv
// Directed bench for piezo_rx_qualifier (BLANK_CYCLES shortened to 50).
// Inputs are driven and outputs sampled 1 time unit after each rising edge;
// "edge 0" is the first edge that samples a newly driven raw level.
module tb_piezo_rx_qualifier;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        piezo_raw_in;
    logic        tx_active;
    logic        clear_counts;
    logic        pulse_out;
    logic [15:0] pulse_count;
    logic [15:0] glitch_count;
    logic [2:0]  state_out;

    int n_chk = 0;
    int n_err = 0;
    int first;
    int np;

    piezo_rx_qualifier #(
        .SYNC_STAGES(2), .MIN_HIGH(8), .HOLDOFF_CYCLES(1000), .BLANK_CYCLES(50)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .piezo_raw_in(piezo_raw_in), .tx_active(tx_active),
        .clear_counts(clear_counts), .pulse_out(pulse_out),
        .pulse_count(pulse_count), .glitch_count(glitch_count),
        .state_out(state_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance n edges; report the edge index of the first strobe and strobe count
    task automatic watch(input int n, output int f, output int cnt);
        f   = -1;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pulse_out) begin
                cnt++;
                if (f < 0) f = i;
            end
        end
    endtask

    // One-cycle raw high from ARMED; the reject lands on the fourth edge
    task automatic glitch(input logic clr);
        piezo_raw_in = 1'b1;
        tick();
        piezo_raw_in = 1'b0;
        tick();
        tick();
        clear_counts = clr;
        tick();
        clear_counts = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; piezo_raw_in = 1'b0;
        tx_active = 1'b0; clear_counts = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_pulse", 32'(pulse_out), 32'd0);
        chk("rst_pcnt", 32'(pulse_count), 32'd0);
        chk("rst_gcnt", 32'(glitch_count), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_dis", 32'(state_out), 32'd0);
        enable = 1'b1;
        tick();
        chk("armed", 32'(state_out), 32'd1);

        // Echo: held high 20 cycles, single strobe at edge 9
        piezo_raw_in = 1'b1;
        watch(20, first, np);
        chk("echo_edge", 32'(first), 32'd9);
        chk("echo_npulse", 32'(np), 32'd1);
        chk("echo_pcnt", 32'(pulse_count), 32'd1);
        chk("echo_holdoff", 32'(state_out), 32'd3);
        // Holdoff expires at edge 1009; first low sample re-arms at edge 1010
        piezo_raw_in = 1'b0;
        repeat (990) tick();
        chk("hold_last", 32'(state_out), 32'd3);
        tick();
        chk("hold_rearm", 32'(state_out), 32'd1);

        // Short high of 5 cycles is rejected
        piezo_raw_in = 1'b1;
        watch(5, first, np);
        chk("glitch_np_a", 32'(np), 32'd0);
        piezo_raw_in = 1'b0;
        watch(5, first, np);
        chk("glitch_np_b", 32'(np), 32'd0);
        chk("glitch_gcnt", 32'(glitch_count), 32'd1);
        chk("glitch_state", 32'(state_out), 32'd1);

        // Transmit with raw high, then 50 blank cycles
        tx_active = 1'b1; piezo_raw_in = 1'b1;
        watch(100, first, np);
        chk("tx_np", 32'(np), 32'd0);
        chk("tx_blank", 32'(state_out), 32'd4);
        tx_active = 1'b0; piezo_raw_in = 1'b0;
        watch(49, first, np);
        chk("blank_np", 32'(np), 32'd0);
        chk("blank_still", 32'(state_out), 32'd4);
        tick();
        chk("blank_rearm", 32'(state_out), 32'd1);
        chk("blank_pcnt", 32'(pulse_count), 32'd1);
        chk("blank_gcnt", 32'(glitch_count), 32'd1);

        // Accept counter saturation
        force dut.pulse_cnt_q = 16'hFFFF;
        tick();
        release dut.pulse_cnt_q;
        tick();
        chk("psat_preset", 32'(pulse_count), 32'hFFFF);
        piezo_raw_in = 1'b1;
        watch(12, first, np);
        chk("psat_edge", 32'(first), 32'd9);
        chk("psat_pcnt", 32'(pulse_count), 32'hFFFF);
        piezo_raw_in = 1'b0;
        repeat (1000) tick();
        chk("psat_rearm", 32'(state_out), 32'd1);

        // Reject counter saturation, then clear beating a simultaneous reject
        force dut.glitch_cnt_q = 16'hFFFE;
        tick();
        release dut.glitch_cnt_q;
        tick();
        glitch(1'b0);
        chk("gsat_ffff", 32'(glitch_count), 32'hFFFF);
        glitch(1'b0);
        chk("gsat_hold", 32'(glitch_count), 32'hFFFF);
        glitch(1'b1);
        chk("clr_gcnt", 32'(glitch_count), 32'd0);
        chk("clr_pcnt", 32'(pulse_count), 32'd0);
        glitch(1'b0);
        chk("clr_resume", 32'(glitch_count), 32'd1);

        // Reset mid-qualify, released with raw still high
        piezo_raw_in = 1'b1;
        repeat (6) tick();
        chk("mid_qual", 32'(state_out), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_pcnt", 32'(pulse_count), 32'd0);
        chk("arst_gcnt", 32'(glitch_count), 32'd0);
        np = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (pulse_out || state_out != 3'd0) np++;
        end
        chk("arst_hold", 32'(np), 32'd0);
        reset_n = 1'b1;
        watch(12, first, np);
        chk("rel_edge", 32'(first), 32'd9);
        chk("rel_np", 32'(np), 32'd1);
        chk("rel_pcnt", 32'(pulse_count), 32'd1);
        chk("rel_state", 32'(state_out), 32'd3);

        // Disable mid-holdoff, then re-enable with raw low
        repeat (5) tick();
        enable = 1'b0;
        tick();
        chk("dis_idle", 32'(state_out), 32'd0);
        chk("dis_pcnt", 32'(pulse_count), 32'd1);
        piezo_raw_in = 1'b0;
        repeat (3) tick();
        chk("dis_stay", 32'(state_out), 32'd0);
        enable = 1'b1;
        tick();
        chk("reen_armed", 32'(state_out), 32'd1);
        tick();
        chk("reen_stay", 32'(state_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
